// File: rtl/mdsa_shear_sorter_pkg.sv
// Shared types and helpers for the shear sorter: FSM state encoding,
// phase count as a function of matrix side, and element comparison.
package mdsa_shear_sorter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SORT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Widest element the comparator handles; elements are zero-extended to it.
   localparam int MAX_DW = 64;

   // Shear sort needs log2(N)+1 row phases interleaved with log2(N) column phases.
   function automatic int phase_count(input int n);
      return 2 * $clog2(n) + 1;
   endfunction

   // a > b for dw-bit elements. Signed mode flips the sign bit so that an
   // unsigned compare of the biased values orders two's-complement numbers.
   function automatic logic elem_gt(input logic [MAX_DW-1:0] a,
                                    input logic [MAX_DW-1:0] b,
                                    input logic              is_signed,
                                    input int                dw);
      logic [MAX_DW-1:0] sign_mask;
      logic [MAX_DW-1:0] ka;
      logic [MAX_DW-1:0] kb;
      sign_mask = is_signed ? (MAX_DW'(1) << (dw - 1)) : '0;
      ka = a ^ sign_mask;
      kb = b ^ sign_mask;
      return ka > kb;
   endfunction

endpackage

// File: rtl/mdsa_oet_lane.sv
// One combinational odd-even transposition step over an N-element lane.
// odd_step=0 pairs (0,1),(2,3)..; odd_step=1 pairs (1,2),(3,4)..
// desc=0 leaves the smaller element at the lower index.
module mdsa_oet_lane
   import mdsa_shear_sorter_pkg::*;
#(
   parameter int N      = 8,
   parameter int DW     = 32,
   parameter int SIGNED = 0
) (
   input  logic [N*DW-1:0] lane_in,
   input  logic            odd_step,
   input  logic            desc,
   output logic [N*DW-1:0] lane_out
);

   // swap[gi] is set when the pair (gi, gi+1) is active this step and out of order
   logic [N-2:0] swap;

   genvar gi;
   generate
      for (gi = 0; gi < N - 1; gi++) begin : g_pair
         localparam logic PAIR_ODD = ((gi % 2) == 1);
         logic [DW-1:0] lo_elem;
         logic [DW-1:0] hi_elem;
         logic          lo_gt_hi;
         logic          hi_gt_lo;
         assign lo_elem  = lane_in[gi*DW +: DW];
         assign hi_elem  = lane_in[(gi+1)*DW +: DW];
         // Strict compares only, so equal elements never move
         assign lo_gt_hi = elem_gt(MAX_DW'(lo_elem), MAX_DW'(hi_elem), SIGNED != 0, DW);
         assign hi_gt_lo = elem_gt(MAX_DW'(hi_elem), MAX_DW'(lo_elem), SIGNED != 0, DW);
         assign swap[gi] = (odd_step == PAIR_ODD) && (desc ? hi_gt_lo : lo_gt_hi);
      end

      for (gi = 0; gi < N; gi++) begin : g_elem
         if (gi == 0) begin : g_first
            assign lane_out[gi*DW +: DW] = swap[gi] ? lane_in[(gi+1)*DW +: DW]
                                                    : lane_in[gi*DW +: DW];
         end else if (gi == N - 1) begin : g_last
            assign lane_out[gi*DW +: DW] = swap[gi-1] ? lane_in[(gi-1)*DW +: DW]
                                                      : lane_in[gi*DW +: DW];
         end else begin : g_mid
            assign lane_out[gi*DW +: DW] = swap[gi]   ? lane_in[(gi+1)*DW +: DW] :
                                           swap[gi-1] ? lane_in[(gi-1)*DW +: DW] :
                                                        lane_in[gi*DW +: DW];
         end
      end
   endgenerate

endmodule

// File: rtl/mdsa_shear_sorter.sv
// Shear sorter for an N x N matrix. Alternates row phases (snake direction)
// and column phases, each built from N odd-even transposition steps, one
// step per enabled cycle. Result is snake-ordered, optionally unsnaked.
module mdsa_shear_sorter
   import mdsa_shear_sorter_pkg::*;
#(
   parameter int N         = 8,
   parameter int DW        = 32,
   parameter int SIGNED    = 0,
   parameter int ROW_MAJOR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              desc,
   input  logic [N*N*DW-1:0] data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*N*DW-1:0] data_out,
   output logic              busy
);

   localparam int MW = N * N * DW;
   localparam int RW = N * DW;
   localparam int P  = phase_count(N);
   localparam int SW = $clog2(N);
   localparam int PW = $clog2(P);

   state_t          state_q,     state_d;
   logic [SW-1:0]   step_q,      step_d;
   logic [PW-1:0]   phase_q,     phase_d;
   logic            desc_q,      desc_d;
   logic [MW-1:0]   mat_q,       mat_d;
   logic [MW-1:0]   data_out_q,  data_out_d;
   logic            in_ready_q,  in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q,      busy_d;

   logic [MW-1:0]   row_res;
   logic [MW-1:0]   col_res;
   logic [MW-1:0]   sorted_next;
   logic [MW-1:0]   out_view;
   logic [RW-1:0]   col_in  [N];
   logic [RW-1:0]   col_out [N];

   genvar gi, gr;
   generate
      // Row lanes: even rows sort in the requested direction, odd rows the opposite
      for (gi = 0; gi < N; gi++) begin : g_row
         localparam logic ROW_ODD = ((gi % 2) == 1);
         mdsa_oet_lane #(.N(N), .DW(DW), .SIGNED(SIGNED)) u_row (
            .lane_in  (mat_q[gi*RW +: RW]),
            .odd_step (step_q[0]),
            .desc     (desc_q ^ ROW_ODD),
            .lane_out (row_res[gi*RW +: RW])
         );
      end

      // Column lanes: gather column gi top-to-bottom, sort, scatter back
      for (gi = 0; gi < N; gi++) begin : g_col
         for (gr = 0; gr < N; gr++) begin : g_cell
            assign col_in[gi][gr*DW +: DW]           = mat_q[(gr*N+gi)*DW +: DW];
            assign col_res[(gr*N+gi)*DW +: DW]       = col_out[gi][gr*DW +: DW];
         end
         mdsa_oet_lane #(.N(N), .DW(DW), .SIGNED(SIGNED)) u_col (
            .lane_in  (col_in[gi]),
            .odd_step (step_q[0]),
            .desc     (desc_q),
            .lane_out (col_out[gi])
         );
      end

      // Presentation of the final matrix: odd rows flipped when row-major output is wanted
      for (gr = 0; gr < N; gr++) begin : g_view_row
         for (gi = 0; gi < N; gi++) begin : g_view_col
            if ((ROW_MAJOR != 0) && ((gr % 2) == 1)) begin : g_flip
               assign out_view[(gr*N+gi)*DW +: DW] = sorted_next[(gr*N+(N-1-gi))*DW +: DW];
            end else begin : g_keep
               assign out_view[(gr*N+gi)*DW +: DW] = sorted_next[(gr*N+gi)*DW +: DW];
            end
         end
      end
   endgenerate

   assign sorted_next = phase_q[0] ? col_res : row_res;

   // Next-state, counter and output computation
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      phase_d     = phase_q;
      desc_d      = desc_q;
      mat_d       = mat_q;
      data_out_d  = data_out_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  mat_d      = data_in;
                  desc_d     = desc;
                  step_d     = '0;
                  phase_d    = '0;
                  state_d    = ST_SORT;
                  in_ready_d = 1'b0;
                  busy_d     = 1'b1;
               end
            end
            ST_SORT: begin
               mat_d = sorted_next;
               if (step_q == SW'(N - 1)) begin
                  step_d = '0;
                  if (phase_q == PW'(P - 1)) begin
                     // Final step: latch the presented result together with out_valid
                     state_d     = ST_DONE;
                     busy_d      = 1'b0;
                     out_valid_d = 1'b1;
                     data_out_d  = out_view;
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  in_ready_d  = 1'b1;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset wins over enable
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         phase_q     <= '0;
         desc_q      <= 1'b0;
         mat_q       <= '0;
         data_out_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         phase_q     <= phase_d;
         desc_q      <= desc_d;
         mat_q       <= mat_d;
         data_out_q  <= data_out_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mdsa_shear_sorter.sv
// Bench for the shear sorter: two instances share stimulus, one unsigned
// snake-ordered, one signed row-major. Expected matrices come from a
// behavioural full sort placed in snake / row-major order.
module tb_mdsa_shear_sorter;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int NN = N * N;
   localparam int MW = NN * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          in_valid;
   logic          desc;
   logic [MW-1:0] data_in;
   logic          out_ready;

   logic          sn_in_ready, sn_out_valid, sn_busy;
   logic [MW-1:0] sn_data_out;
   logic          rm_in_ready, rm_out_valid, rm_busy;
   logic [MW-1:0] rm_data_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [MW-1:0] exp_sn;
      logic [MW-1:0] exp_rm;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      string         name;
      logic [MW-1:0] data;
      logic          dsc;
      int            exp_lat;
   } vec_t;
   vec_t vecs[6];

   mdsa_shear_sorter #(.N(N), .DW(DW), .SIGNED(0), .ROW_MAJOR(0)) u_sn (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(sn_in_ready),
      .desc(desc), .data_in(data_in), .out_valid(sn_out_valid), .out_ready(out_ready),
      .data_out(sn_data_out), .busy(sn_busy)
   );

   mdsa_shear_sorter #(.N(N), .DW(DW), .SIGNED(1), .ROW_MAJOR(1)) u_rm (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rm_in_ready),
      .desc(desc), .data_in(data_in), .out_valid(rm_out_valid), .out_ready(out_ready),
      .data_out(rm_data_out), .busy(rm_busy)
   );

   always #5 clk = ~clk;

   function automatic logic tb_less(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sgn);
      if (sgn) return $signed(a) < $signed(b);
      return a < b;
   endfunction

   // Full sort of all elements, then laid out in snake or row-major order
   function automatic logic [MW-1:0] model(input logic [MW-1:0] d, input logic dsc,
                                           input logic sgn, input logic rm);
      logic [DW-1:0] v [NN];
      logic [DW-1:0] t;
      logic [MW-1:0] res;
      int r, p, c;
      for (int k = 0; k < NN; k++) v[k] = d[k*DW +: DW];
      for (int i = 0; i < NN - 1; i++) begin
         for (int j = 0; j < NN - 1 - i; j++) begin
            if (dsc ? tb_less(v[j], v[j+1], sgn) : tb_less(v[j+1], v[j], sgn)) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
         end
      end
      res = '0;
      for (int k = 0; k < NN; k++) begin
         r = k / N;
         p = k % N;
         c = ((r % 2 == 1) && !rm) ? (N - 1 - p) : p;
         res[(r*N+c)*DW +: DW] = v[k];
      end
      return res;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_mat(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      int bad;
      bad = -1;
      n_checks++;
      for (int k = NN - 1; k >= 0; k--)
         if (act[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: element %0d got 0x%08h, expected 0x%08h",
                  name, bad, act[bad*DW +: DW], exp[bad*DW +: DW]);
      end
   endtask

   // Present a matrix and take it on the next edge; expected results are queued
   task automatic do_accept(input logic [MW-1:0] d, input logic dsc);
      int guard;
      guard = 0;
      en = 1'b1;
      @(negedge clk);
      while (!sn_in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_before_accept", {63'd0, sn_in_ready}, 64'd1);
      in_valid = 1'b1;
      data_in  = d;
      desc     = dsc;
      sb_q.push_back('{exp_sn: model(d, dsc, 1'b0, 1'b0), exp_rm: model(d, dsc, 1'b1, 1'b1)});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in  = ~d;
      desc     = ~dsc;
   endtask

   // Count enabled edges until out_valid appears; latency is in enabled cycles
   task automatic wait_done(input bit toggle, output int lat);
      int  cnt;
      bit  seen;
      cnt  = 0;
      seen = 0;
      for (int it = 0; it < 1000; it++) begin
         @(negedge clk);
         if (sn_out_valid) begin
            seen = 1;
            break;
         end
         en = toggle ? ~en : 1'b1;
         @(posedge clk);
         if (en) cnt++;
      end
      en  = 1'b1;
      lat = seen ? cnt + 1 : -1;
   endtask

   task automatic check_output(input string tag);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_scoreboard: got empty queue, expected one pending result", tag);
      end else begin
         e = sb_q.pop_front();
         chk_mat({tag, "_snake"}, sn_data_out, e.exp_sn);
         chk_mat({tag, "_rowmajor"}, rm_data_out, e.exp_rm);
      end
      chk({tag, "_out_valid"}, {62'd0, rm_out_valid, sn_out_valid}, 64'd3);
      chk({tag, "_in_ready_done"}, {62'd0, rm_in_ready, sn_in_ready}, 64'd0);
      chk({tag, "_busy_done"}, {62'd0, rm_busy, sn_busy}, 64'd0);
      $display("txn %s: latency checked, outputs compared", tag);
   endtask

   // Consume the result; block must be back in IDLE on the next cycle
   task automatic release_out(input string tag);
      out_ready = 1'b1;
      en        = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, {62'd0, rm_in_ready, sn_in_ready}, 64'd3);
      chk({tag, "_out_valid_after"}, {62'd0, rm_out_valid, sn_out_valid}, 64'd0);
   endtask

   logic [MW-1:0] tmp;
   logic [MW-1:0] stall_exp;
   int            lat;

   initial begin
      // Vector table
      for (int k = 0; k < NN; k++) tmp[k*DW +: DW] = 32'(63 - k);
      vecs[0] = '{name: "rev_asc",  data: tmp, dsc: 1'b0, exp_lat: 57};
      vecs[1] = '{name: "rev_desc", data: tmp, dsc: 1'b1, exp_lat: 57};
      for (int k = 0; k < NN; k++) tmp[k*DW +: DW] = $urandom;
      tmp[5*DW +: DW]  = 32'h8000_0000;
      tmp[40*DW +: DW] = 32'h7FFF_FFFF;
      vecs[2] = '{name: "signed_ext", data: tmp, dsc: 1'b0, exp_lat: 57};
      for (int k = 0; k < NN; k++) tmp[k*DW +: DW] = 32'h5A5A_5A5A;
      vecs[3] = '{name: "all_equal", data: tmp, dsc: 1'b0, exp_lat: 57};
      for (int k = 0; k < NN; k++) tmp[k*DW +: DW] = $urandom;
      vecs[4] = '{name: "rand_desc", data: tmp, dsc: 1'b1, exp_lat: 57};
      for (int k = 0; k < NN; k++) tmp[k*DW +: DW] = 32'($urandom_range(0, 7)) - 32'd3;
      vecs[5] = '{name: "dups_asc", data: tmp, dsc: 1'b0, exp_lat: 57};

      // Reset with enable low: reset must still win
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; desc = 1'b0; out_ready = 1'b0; data_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", {62'd0, rm_in_ready, sn_in_ready}, 64'd3);
      chk("reset_out_valid", {62'd0, rm_out_valid, sn_out_valid}, 64'd0);
      chk("reset_busy", {62'd0, rm_busy, sn_busy}, 64'd0);
      chk_mat("reset_data_out", sn_data_out | rm_data_out, '0);
      rst = 1'b0;

      // Table-driven transactions
      for (int i = 0; i < 6; i++) begin
         do_accept(vecs[i].data, vecs[i].dsc);
         chk({vecs[i].name, "_busy_sort"}, {62'd0, rm_busy, sn_busy}, 64'd3);
         wait_done(1'b0, lat);
         chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
         check_output(vecs[i].name);
         if (vecs[i].name == "signed_ext") begin
            chk("signed_min_elem0", 64'(rm_data_out[0 +: DW]), 64'h8000_0000);
            chk("signed_max_elem63", 64'(rm_data_out[63*DW +: DW]), 64'h7FFF_FFFF);
         end
         if (vecs[i].name == "all_equal")
            chk_mat("all_equal_unchanged", rm_data_out, vecs[i].data);
         release_out(vecs[i].name);
      end

      // Hold in DONE for 20 cycles with in_valid pulses that must be ignored
      do_accept(vecs[0].data, 1'b0);
      stall_exp = sb_q[0].exp_rm;
      wait_done(1'b0, lat);
      chk("stall_latency", 64'(lat), 64'd57);
      check_output("stall");
      for (int c = 0; c < 20; c++) begin
         in_valid = c[0];
         data_in  = {NN{$urandom}};
         @(negedge clk);
         chk_mat("stall_data_stable", rm_data_out, stall_exp);
         chk("stall_flags", {61'd0, sn_in_ready, rm_out_valid, sn_out_valid}, 64'd3);
      end
      in_valid = 1'b0;
      release_out("stall");

      // Enable toggled every cycle during the sort
      do_accept(vecs[0].data, 1'b0);
      wait_done(1'b1, lat);
      chk("en_toggle_latency", 64'(lat), 64'd57);
      check_output("en_toggle");
      release_out("en_toggle");

      // Reset at phase 2, step 3, then an immediate new matrix
      do_accept(vecs[0].data, 1'b0);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      chk("midrst_in_ready", {62'd0, rm_in_ready, sn_in_ready}, 64'd3);
      chk("midrst_out_valid", {62'd0, rm_out_valid, sn_out_valid}, 64'd0);
      chk("midrst_busy", {62'd0, rm_busy, sn_busy}, 64'd0);
      chk_mat("midrst_data_out", sn_data_out | rm_data_out, '0);
      do_accept(vecs[1].data, 1'b1);
      wait_done(1'b0, lat);
      chk("post_rst_latency", 64'(lat), 64'd57);
      check_output("post_rst");
      release_out("post_rst");

      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
